ram_arbiter: RTL

Two-port arbiter and access sequencer for the shared 16x8 program/data RAM. Port 0 is the CPU memory path (MAR/RAM accesses during fetch/execute); port 1 is the program loader/debug interface. It arbitrates round-robin with a bounded loader burst lock, and drives a single synchronous RAM port with configurable read latency. It also returns ack/rdata to the winner and raises a CPU stall while the CPU waits.

---
 rtl/ram_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-port arbiter sequencing a single synchronous RAM port
module ram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic [1:0]        gnt,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic              cpu_stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;
  state_t      state;
  logic        last_owner;
  logic        fresh;
  logic        we_q;
  logic [1:0]  wait_cnt;
  logic [3:0]  burst_cnt;
  logic        win1;
  // fresh keeps the lock from overriding the first grant after reset, so the CPU always goes first
  assign win1 = req1 & (~req0 | ~last_owner | (lock1 & ~fresh & (burst_cnt < 4'(MAX_BURST))));
  assign cpu_stall = req0 & ~gnt[0];
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      ack        <= '0;
      rdata      <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      last_owner <= 1'b1;
      fresh      <= 1'b1;
      we_q       <= 1'b0;
      wait_cnt   <= '0;
      burst_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (req0 | req1) begin
          gnt       <= win1 ? 2'b10 : 2'b01;
          ram_en    <= 1'b1;
          ram_we    <= win1 ? we1 : we0;
          we_q      <= win1 ? we1 : we0;
          ram_addr  <= win1 ? addr1 : addr0;
          ram_wdata <= win1 ? wdata1 : wdata0;
          burst_cnt <= (win1 & req0) ? burst_cnt + 4'd1 : 4'd0;
          fresh     <= 1'b0;
          state     <= ACCESS;
        end
        ACCESS: begin
          ram_en   <= 1'b0;
          ram_we   <= 1'b0;
          wait_cnt <= '0;
          ack      <= we_q ? gnt : 2'b00;
          state    <= we_q ? ACK : WAIT;
        end
        WAIT: if (wait_cnt == 2'(RD_LATENCY - 1)) begin
          rdata <= ram_rdata;
          ack   <= gnt;
          state <= ACK;
        end else begin
          wait_cnt <= wait_cnt + 2'd1;
        end
        ACK: begin
          gnt        <= '0;
          ack        <= '0;
          last_owner <= gnt[1];
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
